axis_pool_edge_packer: RTL

Receiving end of the max-pool output stream. Consumes edge-padded beats of 2 cores × GROUPS × UNITS_EDGES words, strips the KERNEL_H_MAX/2 zero-pad units on each side of every (core, group), and compacts the tkeep-qualified words. It emits them as a dense M_WORDS-wide AXI-Stream toward the output DMA, preserving packet boundaries.

---
 rtl/pool_packer_pkg.sv | 29 ++
 rtl/pool_word_compactor.sv | 54 +++++
 rtl/axis_pool_edge_packer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pool_packer_pkg.sv
// Shared configuration for the max-pool edge packer: geometry constants,
// derived buffer sizing, FSM state encoding and the padded word index helper.
package pool_packer_pkg;

  localparam int UNITS        = 8;
  localparam int GROUPS       = 2;
  localparam int WORD_WIDTH   = 8;
  localparam int KERNEL_H_MAX = 3;
  localparam int M_WORDS      = 8;

  localparam int PAD         = KERNEL_H_MAX / 2;
  localparam int UNITS_EDGES = UNITS + 2 * PAD;
  localparam int IN_WORDS    = 2 * GROUPS * UNITS_EDGES;
  localparam int N           = 2 * GROUPS * UNITS;
  localparam int BUF_WORDS   = N + M_WORDS - 1;
  localparam int COUNT_W     = $clog2(N + M_WORDS);
  localparam int KEPT_W      = $clog2(N + 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Flat word index of (core, group, unit) for a given number of units per group.
  function automatic int word_index(input int c, input int g, input int u, input int units_per);
    return c * GROUPS * units_per + g * units_per + u;
  endfunction

endpackage

// File: rtl/pool_word_compactor.sv
// Combinational strip + compaction: removes the PAD edge units of every
// (core, group), then packs the keep-qualified words densely from word 0
// in ascending stripped-index order. Words above kept_count are zero.
module pool_word_compactor
  import pool_packer_pkg::*;
(
  input  logic [IN_WORDS*WORD_WIDTH-1:0] data_in,
  input  logic [IN_WORDS-1:0]            keep_in,
  output logic [N*WORD_WIDTH-1:0]        dense,
  output logic [KEPT_W-1:0]              kept_count
);

  int   pos;
  int   src;
  logic unused_pads;

  // Walk the interior units in order and append each kept word at the next free slot.
  always_comb begin
    dense = '0;
    pos   = 0;
    src   = 0;
    for (int c = 0; c < 2; c++) begin
      for (int g = 0; g < GROUPS; g++) begin
        for (int u = 0; u < UNITS; u++) begin
          src = word_index(c, g, u + PAD, UNITS_EDGES);
          if (keep_in[src]) begin
            dense[pos*WORD_WIDTH +: WORD_WIDTH] = data_in[src*WORD_WIDTH +: WORD_WIDTH];
            pos = pos + 1;
          end else begin
            pos = pos;
          end
        end
      end
    end
    kept_count = KEPT_W'(pos);
  end

  // Pad words are intentionally discarded here; fold them so they are visibly consumed.
  always_comb begin
    unused_pads = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int g = 0; g < GROUPS; g++) begin
        for (int p = 0; p < PAD; p++) begin
          unused_pads = unused_pads
                      ^ (^data_in[word_index(c, g, p, UNITS_EDGES)*WORD_WIDTH +: WORD_WIDTH])
                      ^ keep_in[word_index(c, g, p, UNITS_EDGES)]
                      ^ (^data_in[word_index(c, g, UNITS_EDGES-PAD+p, UNITS_EDGES)*WORD_WIDTH +: WORD_WIDTH])
                      ^ keep_in[word_index(c, g, UNITS_EDGES-PAD+p, UNITS_EDGES)];
        end
      end
    end
  end

endmodule

// File: rtl/axis_pool_edge_packer.sv
// Receiving end of the max-pool output stream: strips edge padding, compacts
// kept words into a word buffer and re-emits them as dense M_WORDS-wide beats
// with packet boundaries preserved. All handshake outputs are registered.
// Optional feature: define POOL_PACKER_PAD_CHECK_EN to enable the sticky
// pad-word check on err; otherwise err is tied low.
module axis_pool_edge_packer
  import pool_packer_pkg::*;
(
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [IN_WORDS*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic [IN_WORDS-1:0]            s_axis_tkeep,
  input  logic                           s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [M_WORDS*WORD_WIDTH-1:0]  m_axis_tdata,
  output logic [M_WORDS-1:0]             m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic                           err
);

  localparam int                 BUF_BITS = BUF_WORDS * WORD_WIDTH;
  localparam int                 OUT_BITS = M_WORDS * WORD_WIDTH;
  localparam logic [COUNT_W-1:0] M_CNT    = COUNT_W'(M_WORDS);

  logic [N*WORD_WIDTH-1:0] dense;
  logic [KEPT_W-1:0]       kept_count;

  state_t                  state, state_nx;
  logic [BUF_BITS-1:0]     buffer, buffer_nx;
  logic [COUNT_W-1:0]      count, count_nx, pop_n, avail_nx;
  logic                    push, pop;
  logic                    ready_nx, valid_nx, last_nx;
  logic [M_WORDS-1:0]      keep_nx;
  logic [OUT_BITS-1:0]     data_nx;

  pool_word_compactor u_compactor (
    .data_in    (s_axis_tdata),
    .keep_in    (s_axis_tkeep),
    .dense      (dense),
    .kept_count (kept_count)
  );

  assign push  = s_axis_tvalid & s_axis_tready;
  assign pop   = m_axis_tvalid & m_axis_tready;
  assign pop_n = (count < M_CNT) ? count : M_CNT;

  // Next buffer, count and FSM state; push and pop are mutually exclusive by construction.
  always_comb begin
    buffer_nx = buffer;
    count_nx  = count;
    state_nx  = state;
    if (push) begin
      buffer_nx = buffer | (BUF_BITS'(dense) << (int'(count) * WORD_WIDTH));
      count_nx  = count + COUNT_W'(kept_count);
    end else if (pop) begin
      buffer_nx = buffer >> (int'(pop_n) * WORD_WIDTH);
      count_nx  = count - pop_n;
    end else begin
      buffer_nx = buffer;
      count_nx  = count;
    end
    case (state)
      FILL: begin
        if (push && s_axis_tlast) state_nx = DRAIN;
        else                      state_nx = FILL;
      end
      DRAIN: begin
        if (pop && (count <= M_CNT)) state_nx = FILL;
        else                         state_nx = DRAIN;
      end
      default: state_nx = FILL;
    endcase
  end

  // Decode the next cycle's output beat from the next state so the ports can be registered.
  always_comb begin
    avail_nx = (count_nx < M_CNT) ? count_nx : M_CNT;
    ready_nx = 1'b0;
    valid_nx = 1'b0;
    last_nx  = 1'b0;
    keep_nx  = '0;
    data_nx  = '0;
    case (state_nx)
      FILL: begin
        ready_nx = (count_nx < M_CNT);
        valid_nx = (count_nx >= M_CNT);
        last_nx  = 1'b0;
        if (valid_nx) begin
          keep_nx = '1;
          data_nx = buffer_nx[OUT_BITS-1:0];
        end else begin
          keep_nx = '0;
          data_nx = '0;
        end
      end
      DRAIN: begin
        ready_nx = 1'b0;
        valid_nx = 1'b1;
        last_nx  = (count_nx <= M_CNT);
        // Buffer words above count are always zero, so unused lanes read as zero.
        data_nx  = buffer_nx[OUT_BITS-1:0];
        for (int i = 0; i < M_WORDS; i++) begin
          keep_nx[i] = (COUNT_W'(i) < avail_nx);
        end
      end
      default: begin
        ready_nx = 1'b0;
        valid_nx = 1'b0;
      end
    endcase
  end

  // FSM, buffer, count and registered stream outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= FILL;
      buffer        <= '0;
      count         <= '0;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      state         <= state_nx;
      buffer        <= buffer_nx;
      count         <= count_nx;
      s_axis_tready <= ready_nx;
      m_axis_tvalid <= valid_nx;
      m_axis_tlast  <= last_nx;
      m_axis_tkeep  <= keep_nx;
      m_axis_tdata  <= data_nx;
    end
  end

`ifdef POOL_PACKER_PAD_CHECK_EN
  logic pad_bad;
  logic err_q;

  // A pad word is bad if non-zero or if its keep differs from the first interior unit's keep.
  always_comb begin
    pad_bad = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int g = 0; g < GROUPS; g++) begin
        for (int p = 0; p < PAD; p++) begin
          if ((s_axis_tdata[word_index(c, g, p, UNITS_EDGES)*WORD_WIDTH +: WORD_WIDTH] != '0) ||
              (s_axis_tdata[word_index(c, g, UNITS_EDGES-PAD+p, UNITS_EDGES)*WORD_WIDTH +: WORD_WIDTH] != '0) ||
              (s_axis_tkeep[word_index(c, g, p, UNITS_EDGES)] != s_axis_tkeep[word_index(c, g, PAD, UNITS_EDGES)]) ||
              (s_axis_tkeep[word_index(c, g, UNITS_EDGES-PAD+p, UNITS_EDGES)] != s_axis_tkeep[word_index(c, g, PAD, UNITS_EDGES)])) begin
            pad_bad = 1'b1;
          end else begin
            pad_bad = pad_bad;
          end
        end
      end
    end
  end

  // Sticky error flag, set the cycle after an accepted beat with a pad violation.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if (push && pad_bad) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
